n64a_vtiming_meas: RTL and testbench
====================================

# n64a_vtiming_meas

Timing-measurement stage directly downstream of the N64 video demux. It consumes the demuxed sync+RGB word and its valid strobe, and counts horizontal pixel and vertical line positions. It measures line and field lengths, derives PAL/NTSC, progressive/interlaced and field parity, then forwards the video word one cycle later, aligned with its counters. Its `palmode_o` feeds back into the demux parameter vector.

## Interface
- `COLOR_W`, 7: bits per colour channel; video word width is 4+3*COLOR_W.
- `CNT_W`, 10: width of horizontal/vertical counters and length registers.
- `VCLK`  in  1: video clock.
- `nRST`  in  1: reset; asynchronous, active-low.
- `vdata_valid_i`  in  1: one-cycle strobe, new video word present.
- `vdata_i`  in  4+3*COLOR_W: [3+3*COLOR_W:3*COLOR_W] sync {nVSYNC,nCLAMP,nHSYNC,nCSYNC}, below it R,G,B.
- `vdata_valid_o`  out  1: registered copy of `vdata_valid_i`.
- `vdata_o`  out  4+3*COLOR_W: `vdata_i` captured on valid.
- `hcnt_o`  out  CNT_W: pixel index within line of `vdata_o`.
- `vcnt_o`  out  CNT_W: line index within field of `vdata_o`.
- `hlen_o`  out  CNT_W: last complete line length, in valid samples.
- `flen_o`  out  CNT_W: last complete field length, in lines.
- `palmode_o`  out  1: 1 = PAL line structure.
- `interlaced_o`  out  1: 1 = interlaced.
- `field_o`  out  1: parity of current field.
- `vinfo_valid_o`  out  1: mode outputs trustworthy.

## Operation
- All state advances only on cycles with `vdata_valid_i`=1; other cycles hold all state and drop `vdata_valid_o`.
- Edge detect on the previous valid sample: hfall = prev nHSYNC=1 and cur nHSYNC=0; vfall is defined likewise for nVSYNC.
- hfall: `hlen_o` <= hcnt+1, then hcnt <= 0 and vcnt <= vcnt+1.
- Otherwise hcnt <= hcnt+1, saturating at 2^CNT_W-1.
- vfall:
  - `flen_o` <= vcnt+1 and vcnt <= 0; vfall overrides hfall for vcnt.
  - hcnt at the vfall sample is compared to `hlen_o`>>1; below it gives field 0, otherwise field 1.
  - The field candidate is written to `field_o` immediately.
- Field classification at each vfall:
  - palmode candidate = (vcnt+1 > 290).
  - interlaced candidate = |current field length − previous field length| == 1.
- Lost sync:
  - hcnt or vcnt reaching saturation clears `vinfo_valid_o` and the "fields seen" counter.
  - Counters stay saturated until the next respective edge.
- `vinfo_valid_o` rises at the second vfall after reset or after lost sync.
- Reset: every output and internal register is 0, including prev-sync registers. The first sample after reset therefore cannot generate an edge.

## Timing
- Latency is 1 VCLK: `vdata_o`, `hcnt_o` and `vcnt_o` describe the same sample and update the cycle after `vdata_valid_i`.
- The hfall sample is output with `hcnt_o`=0; the vfall sample is output with `vcnt_o`=0.
- `hlen_o`, `flen_o` and the mode outputs update in the same cycle as that 0.
- When hfall and vfall occur on the same sample: hcnt=0, vcnt=0, `hlen_o` and `flen_o` both latch.
- Reset asserted mid-line forces outputs to 0 asynchronously. Measurement restarts from scratch, and `vinfo_valid_o` requires two fresh vfalls.

## Configuration
- `N64A_VINFO_HYST_EN` defined:
  - `palmode_o` and `interlaced_o` change only when the same new candidate value is seen at two consecutive vfalls.
  - A differing intermediate candidate restarts the count.
- `N64A_VINFO_HYST_EN` undefined: `palmode_o` and `interlaced_o` take the candidate at every vfall.
- `field_o` is unaffected by the macro.

## Structure
- Shared package/header:
  - sync bit indices (VSYNC=3, CLAMP=2, HSYNC=1, CSYNC=0).
  - PAL line threshold 290.
  - default CNT_W and COLOR_W.
  - video-word slice macros, shared with the demux.
- One sub-module, `n64a_vmode_filter`: holds the previous field length, the candidate logic and the optional hysteresis counter. It is driven by vfall and the measured field length.
- Counters, edge detection and the data pipeline register live in the top.

## Test plan
- NTSC 240p: fields of 263 lines with 773 samples per line → after the 2nd vfall, `hlen_o`=773, `flen_o`=263, `palmode_o`=0, `interlaced_o`=0, `vinfo_valid_o`=1.
- NTSC 480i: alternating 262/263-line fields; vfall at hcnt 10 and at hcnt 400 (line length 773) → `interlaced_o`=1 and `field_o` alternates 0,1.
- PAL 288p: 313 lines × 794 samples → `palmode_o`=1 and `flen_o`=313. With hysteresis, a single 313-line field inside an NTSC stream leaves `palmode_o`=0.
- Simultaneous hfall+vfall, plus stall cycles (`vdata_valid_i` low for 3 cycles between samples) → counters frozen during stalls, both lengths latch, `hcnt_o`=`vcnt_o`=0.
- Sync loss: nHSYNC held high for 1100 samples → `hcnt_o` saturates at 1023 and `vinfo_valid_o`=0. After normal sync resumes, valid returns at the 2nd vfall.
- Reset mid-field: assert `nRST` at vcnt=100 → all outputs 0 immediately; after release the first sample gives no edge.

Source files
------------

// File: rtl/n64a_vtiming_meas_pkg.sv
// Shared constants and video-word slice macros for the N64 demux and timing stages.
// N64A_VINFO_HYST_EN (optional) enables hysteresis on the video mode outputs.
`ifndef N64A_VWORD_MACROS
`define N64A_VWORD_MACROS
`define N64A_VW_SYNC(w, cw)        w[3*(cw)+3:3*(cw)]
`define N64A_VW_SYNCBIT(w, cw, b)  w[3*(cw)+int'(b)]
`define N64A_VW_R(w, cw)           w[3*(cw)-1:2*(cw)]
`define N64A_VW_G(w, cw)           w[2*(cw)-1:(cw)]
`define N64A_VW_B(w, cw)           w[(cw)-1:0]
`endif

package n64a_vtiming_meas_pkg;

    localparam int DEF_COLOR_W      = 7;
    localparam int DEF_CNT_W        = 10;
    localparam int PAL_LINES_THRESH = 290;

    typedef enum logic [1:0] {
        SB_CSYNC = 2'd0,
        SB_HSYNC = 2'd1,
        SB_CLAMP = 2'd2,
        SB_VSYNC = 2'd3
    } sync_bit_e;

    function automatic int vword_w(input int color_w);
        return 4 + 3 * color_w;
    endfunction

endpackage

// File: rtl/n64a_vtiming_meas_if.sv
// Video word in, timed video word plus measurements out.
interface n64a_vtiming_meas_if
    import n64a_vtiming_meas_pkg::*;
#(
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int CNT_W   = DEF_CNT_W
) ();
    localparam int VW = vword_w(COLOR_W);

    logic             vdata_valid_i;
    logic [VW-1:0]    vdata_i;
    logic             vdata_valid_o;
    logic [VW-1:0]    vdata_o;
    logic [CNT_W-1:0] hcnt_o;
    logic [CNT_W-1:0] vcnt_o;
    logic [CNT_W-1:0] hlen_o;
    logic [CNT_W-1:0] flen_o;
    logic             palmode_o;
    logic             interlaced_o;
    logic             field_o;
    logic             vinfo_valid_o;

    modport master (
        output vdata_valid_i, vdata_i,
        input  vdata_valid_o, vdata_o, hcnt_o, vcnt_o, hlen_o, flen_o,
        input  palmode_o, interlaced_o, field_o, vinfo_valid_o
    );

    modport slave (
        input  vdata_valid_i, vdata_i,
        output vdata_valid_o, vdata_o, hcnt_o, vcnt_o, hlen_o, flen_o,
        output palmode_o, interlaced_o, field_o, vinfo_valid_o
    );
endinterface

// File: rtl/n64a_vmode_filter.sv
// PAL/NTSC and interlace classification from consecutive field lengths.
// With N64A_VINFO_HYST_EN a mode flips only after two consecutive matching candidates.
module n64a_vmode_filter
    import n64a_vtiming_meas_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vfall,
    input  logic [CNT_W-1:0] flen,
    output logic             palmode,
    output logic             interlaced
);
    localparam logic [CNT_W-1:0] PAL_TH = CNT_W'(PAL_LINES_THRESH);

    logic [CNT_W-1:0] prev_flen;
    logic [CNT_W-1:0] diff;
    logic [1:0]       cand;

    assign diff = (flen > prev_flen) ? flen - prev_flen : prev_flen - flen;
    assign cand = {flen > PAL_TH, diff == CNT_W'(1)};

`ifdef N64A_VINFO_HYST_EN
    logic [1:0] pend;

    // pend[i] marks one candidate differing from the current mode; a second one commits it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_flen  <= '0;
            palmode    <= 1'b0;
            interlaced <= 1'b0;
            pend       <= '0;
        end else if (vfall) begin
            prev_flen <= flen;
            if (cand[1] == palmode)   pend[1] <= 1'b0;
            else if (pend[1])         begin palmode <= cand[1]; pend[1] <= 1'b0; end
            else                      pend[1] <= 1'b1;
            if (cand[0] == interlaced) pend[0] <= 1'b0;
            else if (pend[0])          begin interlaced <= cand[0]; pend[0] <= 1'b0; end
            else                       pend[0] <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_flen  <= '0;
            palmode    <= 1'b0;
            interlaced <= 1'b0;
        end else if (vfall) begin
            prev_flen  <= flen;
            palmode    <= cand[1];
            interlaced <= cand[0];
        end
    end
`endif
endmodule

// File: rtl/n64a_vtiming_meas.sv
// Horizontal/vertical position counters, line/field length measurement and video mode detect.
// Mode hysteresis is selected by N64A_VINFO_HYST_EN inside n64a_vmode_filter.
module n64a_vtiming_meas
    import n64a_vtiming_meas_pkg::*;
#(
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               VCLK,
    input  logic               nRST,
    n64a_vtiming_meas_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             hs_n, vs_n;
    logic             prev_hs, prev_vs;
    logic             hfall, vfall, lost;
    logic [CNT_W-1:0] hcnt_nxt, vcnt_nxt, flen_nxt;
    logic [1:0]       fields_seen;

    assign hs_n     = `N64A_VW_SYNCBIT(bus.vdata_i, COLOR_W, SB_HSYNC);
    assign vs_n     = `N64A_VW_SYNCBIT(bus.vdata_i, COLOR_W, SB_VSYNC);
    assign hfall    = prev_hs & ~hs_n;
    assign vfall    = prev_vs & ~vs_n;
    assign flen_nxt = bus.vcnt_o + CNT_W'(1);

    // Both counters saturate so a missing sync parks them at max until the next edge
    always_comb begin
        hcnt_nxt = bus.hcnt_o;
        vcnt_nxt = bus.vcnt_o;
        if (hfall) begin
            hcnt_nxt = '0;
            if (bus.vcnt_o != CNT_MAX) vcnt_nxt = bus.vcnt_o + CNT_W'(1);
        end else if (bus.hcnt_o != CNT_MAX) begin
            hcnt_nxt = bus.hcnt_o + CNT_W'(1);
        end
        if (vfall) vcnt_nxt = '0;
    end

    assign lost = (hcnt_nxt == CNT_MAX) || (vcnt_nxt == CNT_MAX);

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            prev_hs           <= 1'b0;
            prev_vs           <= 1'b0;
            fields_seen       <= '0;
            bus.vdata_valid_o <= 1'b0;
            bus.vdata_o       <= '0;
            bus.hcnt_o        <= '0;
            bus.vcnt_o        <= '0;
            bus.hlen_o        <= '0;
            bus.flen_o        <= '0;
            bus.field_o       <= 1'b0;
            bus.vinfo_valid_o <= 1'b0;
        end else begin
            bus.vdata_valid_o <= bus.vdata_valid_i;
            if (bus.vdata_valid_i) begin
                prev_hs     <= hs_n;
                prev_vs     <= vs_n;
                bus.vdata_o <= bus.vdata_i;
                bus.hcnt_o  <= hcnt_nxt;
                bus.vcnt_o  <= vcnt_nxt;
                if (hfall) bus.hlen_o <= bus.hcnt_o + CNT_W'(1);
                if (vfall) begin
                    bus.flen_o  <= flen_nxt;
                    bus.field_o <= (hcnt_nxt >= (bus.hlen_o >> 1));
                end
                // Trust the mode only after two clean vfalls with no saturation in between
                if (lost) begin
                    fields_seen       <= '0;
                    bus.vinfo_valid_o <= 1'b0;
                end else if (vfall) begin
                    if (fields_seen != 2'd2) fields_seen <= fields_seen + 2'd1;
                    if (fields_seen != 2'd0) bus.vinfo_valid_o <= 1'b1;
                end
            end
        end
    end

    n64a_vmode_filter #(.CNT_W(CNT_W)) u_vmode_filter (
        .clk        (VCLK),
        .rst_n      (nRST),
        .vfall      (bus.vdata_valid_i & vfall),
        .flen       (flen_nxt),
        .palmode    (bus.palmode_o),
        .interlaced (bus.interlaced_o)
    );
endmodule

// File: tb/tb_n64a_vtiming_meas.sv
// Directed bench for n64a_vtiming_meas: 240p, 480i, 288p, coincident edges, stalls, sync loss, reset.
module tb_n64a_vtiming_meas;
    import n64a_vtiming_meas_pkg::*;

    localparam int CW    = 7;
    localparam int NW    = 10;
    localparam int VW    = 4 + 3 * CW;
    localparam int RGB_W = 3 * CW;
`ifdef N64A_VINFO_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    logic VCLK = 1'b0;
    logic nRST = 1'b0;
    always #5 VCLK = ~VCLK;

    n64a_vtiming_meas_if #(.COLOR_W(CW), .CNT_W(NW)) bus ();

    n64a_vtiming_meas #(.COLOR_W(CW), .CNT_W(NW)) dut (
        .VCLK (VCLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [VW-1:0] last_word;
    logic          vlev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One valid sample per clock; returns 1 time unit after the capturing edge
    task automatic put(input logic hs, input logic vs);
        @(negedge VCLK);
        last_word          = {vs, 1'b1, hs, hs & vs, RGB_W'($urandom)};
        bus.vdata_i        = last_word;
        bus.vdata_valid_i  = 1'b1;
        @(posedge VCLK);
        #1;
        bus.vdata_valid_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge VCLK);
        #1;
    endtask

    // Line of len samples, nHSYNC low for the first 4; nVSYNC falls at sample vp (vp<0: none)
    task automatic line(input int len, input int vp);
        for (int i = 0; i < len; i++) begin
            if (i == vp) vlev = 1'b0;
            else if (i == 0) vlev = 1'b1;
            put(i >= 4, vlev);
        end
    endtask

    task automatic lines(input int n, input int len, input int lastlen);
        for (int k = 0; k < n; k++) line((k == n - 1) ? lastlen : len, -1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hcnt"},  32'(bus.hcnt_o), 0);
        chk({tag, "_vcnt"},  32'(bus.vcnt_o), 0);
        chk({tag, "_hlen"},  32'(bus.hlen_o), 0);
        chk({tag, "_flen"},  32'(bus.flen_o), 0);
        chk({tag, "_vdat"},  32'(bus.vdata_o), 0);
        chk({tag, "_vldo"},  32'(bus.vdata_valid_o), 0);
        chk({tag, "_pal"},   32'(bus.palmode_o), 0);
        chk({tag, "_intl"},  32'(bus.interlaced_o), 0);
        chk({tag, "_field"}, 32'(bus.field_o), 0);
        chk({tag, "_vinfo"}, 32'(bus.vinfo_valid_o), 0);
    endtask

    initial begin
        bus.vdata_valid_i = 1'b0;
        bus.vdata_i       = '0;
        vlev              = 1'b1;
        repeat (3) @(posedge VCLK);
        #1;
        chk_all_zero("rst");
        @(negedge VCLK);
        nRST = 1'b1;

        // First sample after reset: prev sync regs are 0, so no edge
        put(1'b0, 1'b1);
        chk("first_hcnt", 32'(bus.hcnt_o), 1);
        chk("first_hlen", 32'(bus.hlen_o), 0);
        chk("first_vldo", 32'(bus.vdata_valid_o), 1);
        chk("first_vdat", 32'(bus.vdata_o), 32'(last_word));
        idle(1);
        chk("stall_vldo", 32'(bus.vdata_valid_o), 0);
        chk("stall_hcnt", 32'(bus.hcnt_o), 1);
        repeat (10) put(1'b1, 1'b1);

        // NTSC 240p: 263-line fields (short lines keep the run small; last line 773)
        line(16, 5);
        lines(261, 16, 16);
        line(16, 5);
        chk("p240_vinfo", 32'(bus.vinfo_valid_o), 1);
        chk("p240_flen",  32'(bus.flen_o), 263);
        chk("p240_hlen",  32'(bus.hlen_o), 16);
        lines(261, 16, 773);
        line(16, 5);
        chk("p240_hlen773", 32'(bus.hlen_o), 773);
        chk("p240_flen2",   32'(bus.flen_o), 263);
        chk("p240_pal",     32'(bus.palmode_o), 0);
        chk("p240_intl",    32'(bus.interlaced_o), 0);
        chk("p240_vinfo2",  32'(bus.vinfo_valid_o), 1);
        chk("p240_field",   32'(bus.field_o), 0);
        chk("p240_hcnt",    32'(bus.hcnt_o), 15);
        chk("p240_vcnt",    32'(bus.vcnt_o), 0);

        // NTSC 480i: fields of 262 then 263 lines, vfall at hcnt 400 then 10
        lines(260, 16, 773);
        line(773, 400);
        chk("i480_flen262", 32'(bus.flen_o), 262);
        chk("i480_field1",  32'(bus.field_o), 1);
        chk("i480_intl_a",  32'(bus.interlaced_o), HYST ? 0 : 1);
        chk("i480_hcnt",    32'(bus.hcnt_o), 772);
        lines(261, 16, 773);
        line(16, 10);
        chk("i480_flen263", 32'(bus.flen_o), 263);
        chk("i480_field0",  32'(bus.field_o), 0);
        chk("i480_intl_b",  32'(bus.interlaced_o), 1);

        // PAL 288p: two 313-line fields
        lines(311, 16, 794);
        line(16, 5);
        chk("pal_flen_a", 32'(bus.flen_o), 313);
        chk("pal_pal_a",  32'(bus.palmode_o), HYST ? 0 : 1);
        chk("pal_intl_a", 32'(bus.interlaced_o), HYST ? 1 : 0);
        lines(311, 16, 794);
        line(16, 5);
        chk("pal_flen_b", 32'(bus.flen_o), 313);
        chk("pal_pal_b",  32'(bus.palmode_o), 1);
        chk("pal_intl_b", 32'(bus.interlaced_o), 0);
        chk("pal_hlen",   32'(bus.hlen_o), 794);

        // Coincident hfall+vfall after a 3-cycle stall
        lines(19, 16, 30);
        chk("sim_pre_hcnt", 32'(bus.hcnt_o), 29);
        chk("sim_pre_vcnt", 32'(bus.vcnt_o), 19);
        idle(3);
        chk("sim_stall_vldo", 32'(bus.vdata_valid_o), 0);
        chk("sim_stall_hcnt", 32'(bus.hcnt_o), 29);
        chk("sim_stall_vcnt", 32'(bus.vcnt_o), 19);
        put(1'b0, 1'b0);
        chk("sim_hcnt",  32'(bus.hcnt_o), 0);
        chk("sim_vcnt",  32'(bus.vcnt_o), 0);
        chk("sim_hlen",  32'(bus.hlen_o), 30);
        chk("sim_flen",  32'(bus.flen_o), 20);
        chk("sim_field", 32'(bus.field_o), 0);
        chk("sim_pal",   32'(bus.palmode_o), HYST ? 1 : 0);
        chk("sim_vdat",  32'(bus.vdata_o), 32'(last_word));
        idle(3);
        put(1'b0, 1'b0);
        chk("sim_post_hcnt", 32'(bus.hcnt_o), 1);

        // Sync loss: nHSYNC stuck high
        repeat (1100) put(1'b1, 1'b1);
        chk("loss_hcnt",  32'(bus.hcnt_o), 1023);
        chk("loss_vinfo", 32'(bus.vinfo_valid_o), 0);
        chk("loss_vcnt",  32'(bus.vcnt_o), 0);
        line(16, 5);
        lines(9, 16, 16);
        chk("resync_vinfo1", 32'(bus.vinfo_valid_o), 0);
        line(16, 5);
        chk("resync_vinfo2", 32'(bus.vinfo_valid_o), 1);
        chk("resync_flen",   32'(bus.flen_o), 11);

        // Asynchronous reset mid-field at vcnt=100
        lines(100, 16, 16);
        chk("mid_vcnt", 32'(bus.vcnt_o), 100);
        @(posedge VCLK);
        #3;
        nRST = 1'b0;
        #1;
        chk_all_zero("arst");
        repeat (2) @(posedge VCLK);
        @(negedge VCLK);
        nRST = 1'b1;
        put(1'b0, 1'b0);
        chk("arst_first_hcnt", 32'(bus.hcnt_o), 1);
        chk("arst_first_vcnt", 32'(bus.vcnt_o), 0);
        chk("arst_first_hlen", 32'(bus.hlen_o), 0);
        chk("arst_first_flen", 32'(bus.flen_o), 0);
        repeat (3) put(1'b1, 1'b1);
        line(16, 5);
        chk("arst_vinfo1", 32'(bus.vinfo_valid_o), 0);
        lines(4, 16, 16);
        line(16, 5);
        chk("arst_vinfo2", 32'(bus.vinfo_valid_o), 1);
        chk("arst_flen",   32'(bus.flen_o), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
